// File: rtl/conv_mac_unit.sv
// conv_mac_unit: single-filter convolution MAC.
// Requests one filter (TAPS weights plus one bias) from the parameter ROM,
// latches it, then turns each window of TAPS streamed pixels into one
// saturated BIT_WIDTH result. The filter is kept for every following window
// until clear is asserted.
// Optional build macro CONV_MAC_RELU_EN: clamps negative results to zero
// after saturation. Timing is the same with or without it.
module conv_mac_unit #(
  parameter int TAPS      = 9,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 20,
  parameter int FRAC_BITS = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          clear,
  output logic                          wb_read,
  input  logic [BIT_WIDTH*(TAPS+1)-1:0] wb_bus,
  input  logic                          pix_valid,
  input  logic [BIT_WIDTH-1:0]          pix_data,
  output logic                          pix_ready,
  output logic                          out_valid,
  output logic [BIT_WIDTH-1:0]          out_data,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2 * BIT_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (BIT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2 ** (BIT_WIDTH-1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_ACCUM,
    S_BIAS,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [BIT_WIDTH-1:0] w [TAPS];
  logic signed [BIT_WIDTH-1:0] bias;
  logic                        w_valid;
  logic        [CNT_W-1:0]     tap_cnt;
  logic signed [ACC_WIDTH-1:0] acc_p0;

  logic                        accept;
  logic                        last_tap;
  logic                        out_fire;
  logic signed [BIT_WIDTH-1:0] pix_s;
  logic signed [BIT_WIDTH-1:0] w_sel;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   bias_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH:0]   shifted;
  logic        [BIT_WIDTH-1:0] sat_val;
  logic        [BIT_WIDTH-1:0] res_p1;

  // Clamp the wide signed sum into the signed BIT_WIDTH output range.
  function automatic logic [BIT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] v);
    logic [BIT_WIDTH-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[BIT_WIDTH-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[BIT_WIDTH-1:0];
    else                  r = v[BIT_WIDTH-1:0];
    return r;
  endfunction

`ifdef CONV_MAC_RELU_EN
  // Negative saturated results become zero.
  function automatic logic [BIT_WIDTH-1:0] relu(input logic [BIT_WIDTH-1:0] v);
    return v[BIT_WIDTH-1] ? '0 : v;
  endfunction
`endif

  assign pix_ready = (state == S_ACCUM) && w_valid;
  assign busy      = (state != S_IDLE);
  assign accept    = pix_valid && pix_ready;
  assign last_tap  = (tap_cnt == CNT_W'(TAPS - 1));
  assign out_fire  = (state == S_OUT) && out_valid && out_ready;

  // Stage p0: weight x pixel product, sign-extended into the accumulator width.
  assign pix_s    = pix_data;
  assign w_sel    = w[tap_cnt];
  assign prod     = w_sel * pix_s;
  assign prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

  // Stage p1: add the pre-shifted bias, rescale, saturate (and optionally ReLU).
  assign acc_ext  = {acc_p0[ACC_WIDTH-1], acc_p0};
  assign bias_ext = {{(ACC_WIDTH+1-BIT_WIDTH){bias[BIT_WIDTH-1]}}, bias} <<< FRAC_BITS;
  assign sum      = acc_ext + bias_ext;
  assign shifted  = sum >>> FRAC_BITS;
  assign sat_val  = saturate(shifted);
`ifdef CONV_MAC_RELU_EN
  assign res_p1   = relu(sat_val);
`else
  assign res_p1   = sat_val;
`endif

  // Next-state decode; clear overrides every other event.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_ACCUM;
      S_ACCUM: if (accept && last_tap) state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_OUT;
      S_OUT:   if (out_fire) state_nxt = S_ACCUM;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Control: ROM strobe, tap counter, filter-valid flag and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_read   <= 1'b0;
      out_valid <= 1'b0;
      tap_cnt   <= '0;
      w_valid   <= 1'b0;
    end else if (clear) begin
      wb_read   <= 1'b0;
      out_valid <= 1'b0;
      tap_cnt   <= '0;
      w_valid   <= 1'b0;
    end else begin
      wb_read <= (state == S_IDLE) && start;
      case (state)
        S_LATCH: begin
          tap_cnt <= '0;
          w_valid <= 1'b1;
        end
        S_ACCUM: if (accept) tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
        S_BIAS:  out_valid <= 1'b1;
        S_OUT: if (out_fire) begin
          out_valid <= 1'b0;
          tap_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath: filter capture, accumulation and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
      bias     <= '0;
      acc_p0   <= '0;
      out_data <= '0;
    end else if (clear) begin
      acc_p0 <= '0;
    end else begin
      case (state)
        S_LATCH: begin
          for (int i = 0; i < TAPS; i++) w[i] <= wb_bus[BIT_WIDTH*i +: BIT_WIDTH];
          bias   <= wb_bus[BIT_WIDTH*TAPS +: BIT_WIDTH];
          acc_p0 <= '0;
        end
        S_ACCUM: if (accept) acc_p0 <= acc_p0 + prod_ext;
        S_BIAS:  out_data <= res_p1;
        S_OUT:   if (out_fire) acc_p0 <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed testbench for conv_mac_unit with a small behavioural parameter ROM.
module tb_conv_mac_unit;

  localparam int TAPS = 9;
  localparam int BW   = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   clear;
  logic                   wb_read;
  wire  [BW*(TAPS+1)-1:0] wb_bus;
  logic                   pix_valid;
  logic [BW-1:0]          pix_data;
  logic                   pix_ready;
  logic                   out_valid;
  logic [BW-1:0]          out_data;
  logic                   out_ready;
  logic                   busy;

  logic [BW*(TAPS+1)-1:0] rom_val;
  logic                   rom_drive;
  int                     rd_cnt = 0;
  int                     tests = 0;
  int                     fails = 0;

  conv_mac_unit #(.TAPS(TAPS), .BIT_WIDTH(BW), .ACC_WIDTH(20), .FRAC_BITS(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .wb_read(wb_read), .wb_bus(wb_bus),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM model: samples wb_read at an edge, drives the bus for the following cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_drive <= 1'b0;
    else        rom_drive <= wb_read;
  end
  assign wb_bus = rom_drive ? rom_val : 'z;

  // Counts ROM read strobes seen at clock edges.
  always @(posedge clk) if (wb_read) rd_cnt <= rd_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rom(input logic [BW-1:0] wv, input logic [BW-1:0] bv);
    for (int i = 0; i < TAPS; i++) rom_val[BW*i +: BW] = wv;
    rom_val[BW*TAPS +: BW] = bv;
  endtask

  task automatic load(input logic [BW-1:0] wv, input logic [BW-1:0] bv);
    set_rom(wv, bv);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic push(input logic [BW-1:0] p);
    pix_valid = 1'b1;
    pix_data  = p;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic run_ramp();
    for (int i = 1; i <= TAPS; i++) push(BW'(i));
  endtask

  task automatic run_const(input logic [BW-1:0] p);
    for (int i = 0; i < TAPS; i++) push(p);
  endtask

  task automatic wait_out(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests++;
    if ({wb_read, pix_ready, out_valid, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=0000", {wb_read, pix_ready, out_valid, busy});
    end
    tests++;
    if (out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got=%h exp=00", out_data);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_basic();
    int rd0;
    rd0 = rd_cnt;
    load(8'h01, 8'h00);
    tests++;
    if (pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_pix_ready got=%b exp=1", pix_ready);
    end
    for (int i = 1; i <= TAPS; i++) begin
      pix_valid = 1'b1;
      pix_data  = BW'(i);
      start     = (i == 1);
      step();
      start = 1'b0;
    end
    pix_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early_valid got=%b exp=0", out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency got=%b exp=1", out_valid);
    end
    tests++;
    if (out_data !== 8'h2D) begin
      fails++;
      $display("FAIL basic_data got=%h exp=2d", out_data);
    end
    tests++;
    if (rd_cnt - rd0 !== 1) begin
      fails++;
      $display("FAIL basic_rd_pulses got=%0d exp=1", rd_cnt - rd0);
    end
    accept_out();
    tests++;
    if ({out_valid, pix_ready} !== 2'b01) begin
      fails++;
      $display("FAIL basic_after_accept got=%b exp=01", {out_valid, pix_ready});
    end
  endtask

  task automatic test_saturation();
    bit to;
    do_clear();
    load(8'h7F, 8'h7F);
    run_const(8'h7F);
    wait_out(to);
    tests++;
    if (to !== 1'b0 || out_data !== 8'h7F) begin
      fails++;
      $display("FAIL sat_pos got=%h timeout=%b exp=7f", out_data, to);
    end
    accept_out();
    do_clear();
    load(8'h80, 8'h00);
    run_const(8'h7F);
    wait_out(to);
    tests++;
`ifdef CONV_MAC_RELU_EN
    if (to !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL sat_neg got=%h timeout=%b exp=00", out_data, to);
    end
`else
    if (to !== 1'b0 || out_data !== 8'h80) begin
      fails++;
      $display("FAIL sat_neg got=%h timeout=%b exp=80", out_data, to);
    end
`endif
    accept_out();
  endtask

  task automatic test_negative();
    bit to;
    do_clear();
    load(8'hFF, 8'h00);
    run_const(8'd10);
    wait_out(to);
    tests++;
`ifdef CONV_MAC_RELU_EN
    if (to !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL negative got=%h timeout=%b exp=00", out_data, to);
    end
`else
    if (to !== 1'b0 || out_data !== 8'hA6) begin
      fails++;
      $display("FAIL negative got=%h timeout=%b exp=a6", out_data, to);
    end
`endif
    accept_out();
  endtask

  task automatic test_backpressure();
    bit to;
    int rd0;
    do_clear();
    rd0 = rd_cnt;
    load(8'h01, 8'h00);
    for (int i = 1; i <= TAPS; i++) begin
      pix_valid = 1'b1;
      pix_data  = BW'(i);
      step();
      pix_valid = 1'b0;
      pix_data  = 8'hEE;
      step();
    end
    wait_out(to);
    tests++;
    if (to !== 1'b0 || out_data !== 8'h2D) begin
      fails++;
      $display("FAIL bp_data got=%h timeout=%b exp=2d", out_data, to);
    end
    pix_valid = 1'b1;
    pix_data  = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if ({out_valid, pix_ready, out_data} !== {2'b10, 8'h2D}) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%b d=%h exp v=1 r=0 d=2d",
                 c, out_valid, pix_ready, out_data);
      end
    end
    pix_valid = 1'b0;
    accept_out();
    run_const(8'd2);
    wait_out(to);
    tests++;
    if (to !== 1'b0 || out_data !== 8'h12) begin
      fails++;
      $display("FAIL bp_second_window got=%h timeout=%b exp=12", out_data, to);
    end
    tests++;
    if (rd_cnt - rd0 !== 1) begin
      fails++;
      $display("FAIL bp_no_reread got=%0d exp=1", rd_cnt - rd0);
    end
    accept_out();
  endtask

  task automatic test_abort();
    bit to;
    do_clear();
    load(8'h01, 8'h05);
    for (int i = 1; i <= 4; i++) push(BW'(i));
    do_clear();
    tests++;
    if ({busy, pix_ready, out_valid} !== 3'b000) begin
      fails++;
      $display("FAIL abort_idle got=%b exp=000", {busy, pix_ready, out_valid});
    end
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_output cyc=%0d got=%b exp=0", c, out_valid);
      end
    end
    load(8'h01, 8'h05);
    run_ramp();
    wait_out(to);
    tests++;
    if (to !== 1'b0 || out_data !== 8'h32) begin
      fails++;
      $display("FAIL abort_second got=%h timeout=%b exp=32", out_data, to);
    end
    accept_out();
    for (int i = 1; i <= TAPS - 1; i++) push(BW'(i));
    pix_valid = 1'b1;
    pix_data  = 8'd9;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    pix_valid = 1'b0;
    step();
    tests++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL abort_clear_priority got=%b exp=00", {busy, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    load(8'h01, 8'h00);
    for (int i = 1; i <= 3; i++) push(BW'(i));
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({wb_read, pix_ready, out_valid, busy, out_data} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid got=%b_%h exp=0000_00",
               {wb_read, pix_ready, out_valid, busy}, out_data);
    end
    step();
    rst_n = 1'b1;
    step();
    load(8'h01, 8'h00);
    run_ramp();
    wait_out(to);
    tests++;
    if (to !== 1'b0 || out_data !== 8'h2D) begin
      fails++;
      $display("FAIL reset_mid_restart got=%h timeout=%b exp=2d", out_data, to);
    end
    accept_out();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    out_ready = 1'b0;
    rom_val   = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_mac_unit.md
Name: conv_mac_unit

Overview:
- Downstream consumer of the weight/bias ROM stage.
- Requests one filter's taps and bias over the flat parameter bus, latches them, then convolves streamed pixel windows.
- Each window is TAPS pixels; output is one saturated BIT_WIDTH result per window.
- Sits between the parameter ROM and the feature-map writer in the conv layer.

Parameters:
- TAPS, 9, kernel taps per window (e.g. 3x3); bus carries TAPS weights then 1 bias.
- BIT_WIDTH, 8, width of weights, bias, pixels and output, signed two's complement.
- ACC_WIDTH, 20, signed accumulator width; must be >= 2*BIT_WIDTH + clog2(TAPS+1).
- FRAC_BITS, 0, arithmetic right shift applied to the accumulator before saturation; bias is pre-shifted left by FRAC_BITS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; loads a new filter. Honoured only in IDLE.
- clear  in  1  synchronous abort to IDLE from any state. Weights are retained but marked invalid.
- wb_read  out  1  read strobe to the parameter ROM. Registered; high for exactly one cycle.
- wb_bus  in  BIT_WIDTH*(TAPS+1)  flat parameter bus. Entry i = wb_bus[BIT_WIDTH*i +: BIT_WIDTH]; entry TAPS = bias. May be high-Z except in the cycle after wb_read.
- pix_valid  in  1  pixel strobe.
- pix_data  in  BIT_WIDTH  signed pixel.
- pix_ready  out  1  high only in ACCUM.
- out_valid  out  1  result valid; held until accepted.
- out_data  out  BIT_WIDTH  signed saturated result.
- out_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; wb_read, pix_ready, out_valid, busy = 0; out_data = 0; accumulator, tap counter and weight registers = 0.
- IDLE: on start go to REQ. start is ignored in every other state.
- REQ (1 cycle): wb_read=1. The ROM samples wb_read at the closing edge and drives the bus from the next cycle.
- LATCH (1 cycle): wb_read=0. At the closing edge capture all TAPS+1 entries into internal registers. Go to ACCUM with tap_cnt=0 and acc=0.
- ACCUM:
  - On each edge with pix_valid && pix_ready: acc += sext(w[tap_cnt]) * sext(pix_data); tap_cnt++.
  - Gaps in pix_valid stall without side effects.
  - When the accepted pixel has tap_cnt==TAPS-1, go to BIAS.
- BIAS (1 cycle):
  - r = (acc + (sext(bias) << FRAC_BITS)) >>> FRAC_BITS.
  - Saturate r to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
  - Register the result into out_data; set out_valid=1; go to OUT.
  - Latency: out_valid rises 2 edges after the last pixel acceptance.
- OUT:
  - out_valid and out_data are held stable while out_ready=0; pix_ready=0 (backpressure).
  - On out_valid && out_ready edge: out_valid=0; acc=0; tap_cnt=0; return to ACCUM. Weights are reused for the next window (no ROM re-read).
- Leaving ACCUM/OUT to reload a filter requires clear then start.
- clear: next edge forces state=IDLE with out_valid=0, wb_read=0, acc=0, tap_cnt=0. clear has priority over every other event in the same cycle, including an out handshake or a last-pixel acceptance.
- Accumulator cannot overflow given the ACC_WIDTH rule; saturation happens only at the output.
- Reset mid-operation (async) returns immediately to reset values; a partial window is discarded.

Optional Feature:
- Macro: CONV_MAC_RELU_EN.
- Defined: ReLU is applied after saturation; negative results output 0.
- Undefined: signed saturated result passes unchanged. Timing is identical in both cases.

Test Plan:
- Basic window: weights all 0x01, bias 0x00, FRAC_BITS=0, start, pixels 1..9 back-to-back -> exactly one wb_read pulse; out_data=45 (0x2D) two edges after the 9th accept.
- Saturation: weights 0x7F, bias 0x7F, pixels 0x7F -> out_data=0x7F. Weights 0x80, pixels 0x7F -> out_data=0x80.
- Negative/ReLU: weights 0xFF, bias 0x00, pixels 10 -> out_data=0xA6 (-90). With CONV_MAC_RELU_EN defined -> 0x00.
- Backpressure/stall: pix_valid toggling 1/0 and out_ready low 5 cycles -> result unchanged (45); out_valid and out_data stable throughout; pix_ready=0 during OUT. A second window then reuses the weights with no new wb_read.
- Abort: clear asserted after 4 pixels, then start and a full window -> first partial window produces no output; second result is correct.
- Reset mid-ACCUM: rst_n low for 1 cycle -> all outputs 0 immediately; a start after release works normally.
